lcd_time_writer: RTL

//  Downstream consumer of the time calculator: accepts six 8-bit LCD character codes (HH MM SS digits).

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_step_strobe.sv | 43 ++++
 rtl/lcd_time_writer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 time writer: state encoding, LCD command
// codes and character constants.
package lcd_pkg;

    typedef enum logic [3:0] {
        StPwrWait,
        StFuncSet,
        StDispOn,
        StEntry,
        StClear,
        StAddr,
        StChar0,
        StChar1,
        StChar2,
        StChar3,
        StChar4,
        StChar5,
        StChar6,
        StChar7,
        StIdle
    } lcd_state_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_SET_ADDR = 8'h80;  // OR'd with DDRAM address

    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SPACE = 8'h20;

    // States that occupy one timed bus step
    function automatic logic is_step(lcd_state_e s);
        return (s != StPwrWait) && (s != StIdle);
    endfunction

endpackage

// File: rtl/lcd_step_strobe.sv
// Bus step timer: counts k = 0..STEP_CYC-1 while a step state is active and
// produces a registered enable strobe high for k = 1..STEP_CYC-2.
module lcd_step_strobe #(
    parameter int unsigned STEP_CYC = 4
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic step_en,
    output logic lcd_e,
    output logic step_last
);

    localparam int unsigned KW = (STEP_CYC > 2) ? $clog2(STEP_CYC) : 1;
    localparam logic [KW-1:0] KLast   = KW'(STEP_CYC - 1);
    localparam logic [KW-1:0] KHiLast = KW'(STEP_CYC - 2);

    logic [KW-1:0] k_q, k_d;
    logic          e_q, e_d;

    assign step_last = step_en && (k_q == KLast);
    assign lcd_e     = e_q;

    // Next step count; wraps to 0 at the step boundary so back-to-back steps restart cleanly
    always_comb begin
        k_d = '0;
        if (step_en && !step_last) begin
            k_d = k_q + KW'(1);
        end
        e_d = (k_d != '0) && (k_d <= KHiLast);
    end

    // Step counter and strobe registers
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            k_q <= '0;
            e_q <= 1'b0;
        end else begin
            k_q <= k_d;
            e_q <= e_d;
        end
    end

endmodule

// File: rtl/lcd_time_writer.sv
// Writes "HH:MM:SS" to line 1 of an HD44780-style LCD once per refresh frame.
// Optional feature macro COLON_BLINK_EN: colons alternate ':'/' ' on successive frames.
module lcd_time_writer
    import lcd_pkg::*;
#(
    parameter int unsigned POWER_CYC   = 10,
    parameter int unsigned STEP_CYC    = 4,
    parameter int unsigned REFRESH_CYC = 20,
    parameter int unsigned COL_OFFSET  = 4
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] in_H10,
    input  logic [7:0] in_H1,
    input  logic [7:0] in_M10,
    input  logic [7:0] in_M1,
    input  logic [7:0] in_S10,
    input  logic [7:0] in_S1,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic       frame_done
);

    localparam int unsigned WaitMax = (POWER_CYC > REFRESH_CYC) ? POWER_CYC : REFRESH_CYC;
    localparam int unsigned WaitW   = $clog2(WaitMax + 1);

    lcd_state_e       state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             fd_q, fd_d;
    logic [5:0][7:0]  digits_q;  // [0]=H10 .. [5]=S1
    logic             snap;
    logic             step_en;
    logic             step_last;
    logic [7:0]       colon_ch;

    assign step_en = is_step(state_q);

    lcd_step_strobe #(
        .STEP_CYC (STEP_CYC)
    ) u_strobe (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .step_en   (step_en),
        .lcd_e     (LCD_E),
        .step_last (step_last)
    );

`ifdef COLON_BLINK_EN
    logic blink_q;

    // Frame parity: flips once per completed frame
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            blink_q <= 1'b0;
        end else if (fd_q) begin
            blink_q <= ~blink_q;
        end
    end

    assign colon_ch = blink_q ? CH_SPACE : CH_COLON;
`else
    assign colon_ch = CH_COLON;
`endif

    // Sequencer next state; wait counter only runs in the two timed wait states
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        unique case (state_q)
            StPwrWait: begin
                if (wait_q == WaitW'(POWER_CYC - 1)) state_d = StFuncSet;
                else                                  wait_d  = wait_q + WaitW'(1);
            end
            StFuncSet: if (step_last) state_d = StDispOn;
            StDispOn:  if (step_last) state_d = StEntry;
            StEntry:   if (step_last) state_d = StClear;
            StClear:   if (step_last) state_d = StAddr;
            StAddr, StChar0, StChar1, StChar2, StChar3, StChar4, StChar5, StChar6: begin
                if (step_last) state_d = lcd_state_e'(state_q + 4'd1);
            end
            StChar7:   if (step_last) state_d = StIdle;
            StIdle: begin
                if (wait_q == WaitW'(REFRESH_CYC - 1)) state_d = StAddr;
                else                                    wait_d  = wait_q + WaitW'(1);
            end
            default:   state_d = StPwrWait;
        endcase
    end

    // Bus values for the state being entered, so RS/DATA are valid from k=0
    always_comb begin
        rs_d   = 1'b0;
        data_d = data_q;
        unique case (state_d)
            StFuncSet: data_d = CMD_FUNC_SET;
            StDispOn:  data_d = CMD_DISP_ON;
            StEntry:   data_d = CMD_ENTRY;
            StClear:   data_d = CMD_CLEAR;
            StAddr:    data_d = CMD_SET_ADDR | 8'(COL_OFFSET);
            StChar0:   begin rs_d = 1'b1; data_d = digits_q[0]; end
            StChar1:   begin rs_d = 1'b1; data_d = digits_q[1]; end
            StChar2:   begin rs_d = 1'b1; data_d = colon_ch;    end
            StChar3:   begin rs_d = 1'b1; data_d = digits_q[2]; end
            StChar4:   begin rs_d = 1'b1; data_d = digits_q[3]; end
            StChar5:   begin rs_d = 1'b1; data_d = colon_ch;    end
            StChar6:   begin rs_d = 1'b1; data_d = digits_q[4]; end
            StChar7:   begin rs_d = 1'b1; data_d = digits_q[5]; end
            default:   ;
        endcase
        fd_d = (state_d == StIdle) && (state_q != StIdle);
        snap = (state_d == StAddr) && (state_q != StAddr);
    end

    // State, bus and snapshot registers
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= StPwrWait;
            wait_q   <= '0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            fd_q     <= 1'b0;
            digits_q <= {6{CH_SPACE}};
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            fd_q    <= fd_d;
            if (snap) digits_q <= {in_S1, in_S10, in_M1, in_M10, in_H1, in_H10};
        end
    end

    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_DATA   = data_q;
    assign frame_done = fd_q;

endmodule
